// File: rtl/sseg_pkg.sv
// Shared constants and types for the seven-segment capture path.
// Active-low segment patterns use seg[0]=a .. seg[6]=g.
package sseg_pkg;

    localparam int BIN_W = 14;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CONV    = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // Debug view: converter state, digits seen in the current frame, synced dp.
    typedef struct packed {
        state_t     state;
        logic [3:0] seen;
        logic       dp_sync;
    } dbg_t;

endpackage

// File: rtl/sseg_seg2bcd.sv
// Combinational decode of an active-low segment pattern to a BCD digit.
// Only exact patterns are accepted; anything else reports bad with digit 0.
module sseg_seg2bcd
    import sseg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_bad
);

    always_comb begin
        o_digit = 4'd0;
        o_bad   = 1'b0;
        case (i_seg)
            SEG_0:   o_digit = 4'd0;
            SEG_1:   o_digit = 4'd1;
            SEG_2:   o_digit = 4'd2;
            SEG_3:   o_digit = 4'd3;
            SEG_4:   o_digit = 4'd4;
            SEG_5:   o_digit = 4'd5;
            SEG_6:   o_digit = 4'd6;
            SEG_7:   o_digit = 4'd7;
            SEG_8:   o_digit = 4'd8;
            SEG_9:   o_digit = 4'd9;
            default: o_bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_capture_bcd2bin.sv
// Monitors multiplexed an/seg/dp lines, rebuilds a 4-digit BCD frame and converts it
// to binary. Define SSEG_CAP_DP_EN to add the dp_pos output (decimal point positions).
module sseg_capture_bcd2bin
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       an,
    input  logic [6:0]       seg,
    input  logic             dp,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BIN_W-1:0] bin,
    output logic             err,
    output logic             overrun,
    output dbg_t             dbg
`ifdef SSEG_CAP_DP_EN
    ,
    output logic [3:0]       dp_pos
`endif
);

    localparam int            DW        = $clog2(STABLE_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(STABLE_CYCLES - 1);
    localparam logic [DW-1:0] DWELL_ARM = DW'(STABLE_CYCLES - 2);

    logic [3:0]       r_an_s1, r_an_s2, r_an_prev;
    logic [6:0]       r_seg_s1, r_seg_s2, r_seg_prev;
    logic             r_dp_s1, r_dp_s2;
    logic [DW-1:0]    r_dwell;

    logic [3:0][3:0]  r_digit;
    logic [3:0]       r_bad;
    logic [3:0]       r_seen;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0][3:0]  r_snap_digit;
    logic [3:0]       r_snap_bad;
    logic [BIN_W-1:0] r_acc;
    logic [1:0]       r_cnt;
    logic             r_out_valid;
    logic [BIN_W-1:0] r_bin;
    logic             r_err;
    logic             r_overrun;

    logic             w_onehot;
    logic [1:0]       w_idx;
    logic             w_stable;
    logic             w_capture;
    logic [3:0]       w_dec_digit;
    logic             w_dec_bad;
    logic             w_frame;
    logic [3:0]       w_seen_next;
    logic             w_snap;
    logic             w_conv_done;
    logic             w_accept;
    logic             w_overrun;
    logic [3:0]       w_cur_digit;
    logic [BIN_W-1:0] w_acc_next;

    // Two-flop synchronizer plus a one-cycle history for change detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an_s1    <= 4'hF;
            r_an_s2    <= 4'hF;
            r_an_prev  <= 4'hF;
            r_seg_s1   <= SEG_BLANK;
            r_seg_s2   <= SEG_BLANK;
            r_seg_prev <= SEG_BLANK;
            r_dp_s1    <= 1'b1;
            r_dp_s2    <= 1'b1;
        end else begin
            r_an_s1    <= an;
            r_an_s2    <= r_an_s1;
            r_an_prev  <= r_an_s2;
            r_seg_s1   <= seg;
            r_seg_s2   <= r_seg_s1;
            r_seg_prev <= r_seg_s2;
            r_dp_s1    <= dp;
            r_dp_s2    <= r_dp_s1;
        end
    end

    always_comb begin
        w_onehot = 1'b1;
        w_idx    = 2'd0;
        case (r_an_s2)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_onehot = 1'b0;
        endcase
    end

    assign w_stable  = w_onehot && (r_an_s2 == r_an_prev) && (r_seg_s2 == r_seg_prev);
    // Fires on the single cycle the dwell count steps onto its saturation value.
    assign w_capture = w_stable && (r_dwell == DWELL_ARM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
        end else if (!w_stable) begin
            r_dwell <= '0;
        end else if (r_dwell != DWELL_MAX) begin
            r_dwell <= r_dwell + 1'b1;
        end
    end

    sseg_seg2bcd u_seg2bcd (
        .i_seg   (r_seg_s2),
        .o_digit (w_dec_digit),
        .o_bad   (w_dec_bad)
    );

    assign w_frame     = (r_seen == 4'b1111);
    assign w_seen_next = (w_frame ? 4'b0000 : r_seen) | (w_capture ? (4'b0001 << w_idx) : 4'b0000);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit <= '0;
            r_bad   <= '0;
            r_seen  <= '0;
        end else begin
            r_seen <= w_seen_next;
            if (w_capture) begin
                r_digit[w_idx] <= w_dec_digit;
                r_bad[w_idx]   <= w_dec_bad;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture keeps running in every state; only the snapshot into the converter is gated.
    always_comb begin
        w_state_next = r_state;
        w_snap       = 1'b0;
        w_conv_done  = 1'b0;
        w_accept     = 1'b0;
        w_overrun    = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_frame) begin
                    w_snap       = 1'b1;
                    w_state_next = CONV;
                end
            end
            CONV: begin
                w_overrun = w_frame;
                if (r_cnt == 2'd3) begin
                    w_conv_done  = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_accept     = 1'b1;
                    w_snap       = w_frame;
                    w_state_next = w_frame ? CONV : COLLECT;
                end else begin
                    w_overrun = w_frame;
                end
            end
            default: w_state_next = COLLECT;
        endcase
    end

    // Thousands digit first; multiply by ten as (acc<<3)+(acc<<1).
    assign w_cur_digit = r_snap_digit[2'd3 - r_cnt];
    assign w_acc_next  = (r_acc << 3) + (r_acc << 1) + {{(BIN_W-4){1'b0}}, w_cur_digit};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap_digit <= '0;
            r_snap_bad   <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_bin        <= '0;
            r_err        <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= w_overrun;
            if (w_snap) begin
                r_snap_digit <= r_digit;
                r_snap_bad   <= r_bad;
                r_acc        <= '0;
                r_cnt        <= '0;
            end else if (r_state == CONV) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_conv_done) begin
                r_bin       <= (|r_snap_bad) ? '0 : w_acc_next;
                r_err       <= |r_snap_bad;
                r_out_valid <= 1'b1;
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SSEG_CAP_DP_EN
    logic [3:0] r_dp_cap;
    logic [3:0] r_snap_dp;
    logic [3:0] r_dp_pos;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dp_cap  <= '0;
            r_snap_dp <= '0;
            r_dp_pos  <= '0;
        end else begin
            if (w_capture) begin
                r_dp_cap[w_idx] <= ~r_dp_s2;
            end
            if (w_snap) begin
                r_snap_dp <= r_dp_cap;
            end
            if (w_conv_done) begin
                r_dp_pos <= r_snap_dp;
            end
        end
    end

    assign dp_pos = r_dp_pos;
`endif

    assign out_valid = r_out_valid;
    assign bin       = r_bin;
    assign err       = r_err;
    assign overrun   = r_overrun;

    always_comb begin
        dbg         = '0;
        dbg.state   = r_state;
        dbg.seen    = r_seen;
        dbg.dp_sync = r_dp_s2;
    end

endmodule
